// File: rtl/gcn_transform_ctrl.sv
// gcn_transform_ctrl
// Sequencer for the GCN feature x weight transform. It walks every weight
// column, and within each column every feature row. It fetches operands over
// the shared FM/WM read port, loads the scratchpad, launches the external
// dot-product unit and commits each result into FM_WM at (row, col).
// The block does no data arithmetic; it only owns addresses, strobes and the
// dot-product handshake. Outputs are registered, and each output register
// takes the decode of the next state. The outputs therefore line up
// cycle-for-cycle with the registered state and are free of glitches.

module gcn_transform_ctrl #(
    parameter int FEATURE_ROWS          = 6,
    parameter int WEIGHT_COLS           = 3,
    parameter int ADDRESS_WIDTH         = 13,
    parameter int WEIGHT_BASE           = 0,
    parameter int FEATURE_BASE          = 512,
    // Degenerate 1-entry dimensions still need a 1-bit index port.
    parameter int COUNTER_WEIGHT_WIDTH  = (WEIGHT_COLS  > 1) ? $clog2(WEIGHT_COLS)  : 1,
    parameter int COUNTER_FEATURE_WIDTH = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             enable_read,
    output logic [ADDRESS_WIDTH-1:0]         read_address,
    output logic                             sp_write_enable,
    output logic                             dp_start,
    input  logic                             dp_done,
    output logic                             wr_en,
    output logic [COUNTER_FEATURE_WIDTH-1:0] write_row,
    output logic [COUNTER_WEIGHT_WIDTH-1:0]  write_col,
    output logic                             busy,
    output logic                             done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_WEIGHT = 3'd1,
        S_LD_WEIGHT = 3'd2,
        S_RD_FEAT   = 3'd3,
        S_LAUNCH    = 3'd4,
        S_COMPUTE   = 3'd5,
        S_WRITE     = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    localparam logic [COUNTER_FEATURE_WIDTH-1:0] ROW_ZERO = {COUNTER_FEATURE_WIDTH{1'b0}};
    localparam logic [COUNTER_FEATURE_WIDTH-1:0] ROW_ONE  = COUNTER_FEATURE_WIDTH'(1);
    localparam logic [COUNTER_FEATURE_WIDTH-1:0] ROW_LAST = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  COL_ZERO = {COUNTER_WEIGHT_WIDTH{1'b0}};
    localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  COL_ONE  = COUNTER_WEIGHT_WIDTH'(1);
    localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  COL_LAST = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);
    localparam logic [ADDRESS_WIDTH-1:0]         ADDR_ZERO = {ADDRESS_WIDTH{1'b0}};
    localparam logic [ADDRESS_WIDTH-1:0]         W_BASE    = ADDRESS_WIDTH'(WEIGHT_BASE);
    localparam logic [ADDRESS_WIDTH-1:0]         F_BASE    = ADDRESS_WIDTH'(FEATURE_BASE);

    state_t                           state_q, state_d;
    logic [COUNTER_FEATURE_WIDTH-1:0] row_q, row_d;
    logic [COUNTER_WEIGHT_WIDTH-1:0]  col_q, col_d;

    logic                             enable_read_q, enable_read_d;
    logic [ADDRESS_WIDTH-1:0]         read_address_q, read_address_d;
    logic                             sp_write_enable_q, sp_write_enable_d;
    logic                             dp_start_q, dp_start_d;
    logic                             wr_en_q, wr_en_d;
    logic [COUNTER_FEATURE_WIDTH-1:0] write_row_q, write_row_d;
    logic [COUNTER_WEIGHT_WIDTH-1:0]  write_col_q, write_col_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;

    // State and index registers; reset abandons any job in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= ROW_ZERO;
            col_q   <= COL_ZERO;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Next-state and counter update. start is only looked at in IDLE/DONE and
    // dp_done only in COMPUTE, so stray pulses elsewhere leave no trace.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    col_d   = COL_ZERO;
                    state_d = S_RD_WEIGHT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_WEIGHT: begin
                state_d = S_LD_WEIGHT;
            end
            S_LD_WEIGHT: begin
                row_d   = ROW_ZERO;
                state_d = S_RD_FEAT;
            end
            S_RD_FEAT: begin
                state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (dp_done) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_COMPUTE;
                end
            end
            S_WRITE: begin
                // Rows advance first, so results are committed column-major.
                if (row_q < ROW_LAST) begin
                    row_d   = row_q + ROW_ONE;
                    state_d = S_RD_FEAT;
                end else if (col_q < COL_LAST) begin
                    col_d   = col_q + COL_ONE;
                    state_d = S_RD_WEIGHT;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Holding start keeps us here; a new job needs start to drop first.
                if (start) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                row_d   = ROW_ZERO;
                col_d   = COL_ZERO;
            end
        endcase
    end

    // Output decode of the upcoming state; address/index buses stay 0 unless strobed.
    always_comb begin
        enable_read_d     = 1'b0;
        read_address_d    = ADDR_ZERO;
        sp_write_enable_d = 1'b0;
        dp_start_d        = 1'b0;
        wr_en_d           = 1'b0;
        write_row_d       = ROW_ZERO;
        write_col_d       = COL_ZERO;
        busy_d            = 1'b1;
        done_d            = 1'b0;
        case (state_d)
            S_IDLE: begin
                busy_d = 1'b0;
            end
            S_RD_WEIGHT: begin
                enable_read_d  = 1'b1;
                read_address_d = W_BASE + ADDRESS_WIDTH'(col_d);
            end
            S_LD_WEIGHT: begin
                sp_write_enable_d = 1'b1;
            end
            S_RD_FEAT: begin
                enable_read_d  = 1'b1;
                read_address_d = F_BASE + ADDRESS_WIDTH'(row_d);
            end
            S_LAUNCH: begin
                dp_start_d = 1'b1;
            end
            S_COMPUTE: begin
                busy_d = 1'b1;
            end
            S_WRITE: begin
                wr_en_d     = 1'b1;
                write_row_d = row_d;
                write_col_d = col_d;
            end
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Output registers; cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_read_q     <= 1'b0;
            read_address_q    <= ADDR_ZERO;
            sp_write_enable_q <= 1'b0;
            dp_start_q        <= 1'b0;
            wr_en_q           <= 1'b0;
            write_row_q       <= ROW_ZERO;
            write_col_q       <= COL_ZERO;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
        end else begin
            enable_read_q     <= enable_read_d;
            read_address_q    <= read_address_d;
            sp_write_enable_q <= sp_write_enable_d;
            dp_start_q        <= dp_start_d;
            wr_en_q           <= wr_en_d;
            write_row_q       <= write_row_d;
            write_col_q       <= write_col_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
        end
    end

    assign enable_read     = enable_read_q;
    assign read_address    = read_address_q;
    assign sp_write_enable = sp_write_enable_q;
    assign dp_start        = dp_start_q;
    assign wr_en           = wr_en_q;
    assign write_row       = write_row_q;
    assign write_col       = write_col_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule
